// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add ops, plus iterative shift-add multiply
// and restoring divide that take one bit per cycle behind a valid/ready handshake.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             alu_z,
  output logic             div0
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH-1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_a_next;   // multiplicand / dividend-quotient shifter
  logic [WIDTH-1:0] op_b_reg, op_b_next;   // multiplier shifter / divisor
  logic [WIDTH-1:0] acc_reg, acc_next;     // partial product / partial remainder
  logic [3:0]       func_reg, func_next;
  logic [SHW:0]     cnt_reg, cnt_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             alu_z_reg, alu_z_next;
  logic             div0_reg, div0_next;

  logic [WIDTH-1:0] quick;
  logic [WIDTH-1:0] prod_sum;
  logic [WIDTH:0]   rem_sh, rem_diff;

  always_comb begin
    quick = '0;
    case (func)
      4'd1:    quick = a - b;
      4'd6:    quick = a << b[SHW-1:0];
      4'd7:    quick = a >> b[SHW-1:0];
      4'd8:    quick = a & b;
      4'd9:    quick = a | b;
      4'd10:   quick = a ^ b;
      4'd13:   quick = {{(WIDTH-1){1'b0}}, a == b};
      4'd14:   quick = {{(WIDTH-1){1'b0}}, a != b};
      default: quick = a + b;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    op_a_next   = op_a_reg;
    op_b_next   = op_b_reg;
    acc_next    = acc_reg;
    func_next   = func_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    alu_z_next  = alu_z_reg;
    div0_next   = div0_reg;

    prod_sum = acc_reg + (op_b_reg[0] ? op_a_reg : '0);
    rem_sh   = {acc_reg, op_a_reg[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, op_b_reg};

    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_a_next = a;
          op_b_next = b;
          func_next = func;
          cnt_next  = '0;
          acc_next  = '0;
          div0_next = 1'b0;
          if (func == 4'd3) begin
            state_next = MUL;
          end else if (func == 4'd4 || func == 4'd5) begin
            if (b == '0) begin
              result_next = (func == 4'd4) ? '1 : a;
              div0_next   = 1'b1;
              state_next  = DONE;
            end else begin
              state_next = DIV;
            end
          end else begin
            result_next = quick;
            state_next  = DONE;
          end
        end
      end
      MUL: begin
        acc_next  = prod_sum;
        op_a_next = op_a_reg << 1;
        op_b_next = op_b_reg >> 1;
        cnt_next  = cnt_reg + (SHW+1)'(1);
        if (cnt_reg == LAST) begin
          result_next = prod_sum;
          state_next  = DONE;
        end
      end
      DIV: begin
        // Restoring step: keep the subtraction only when it did not go negative.
        acc_next  = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        op_a_next = {op_a_reg[WIDTH-2:0], ~rem_diff[WIDTH]};
        cnt_next  = cnt_reg + (SHW+1)'(1);
        if (cnt_reg == LAST) begin
          result_next = (func_reg == 4'd4) ? op_a_next : acc_next;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
    endcase

    if (state_next == DONE && state_reg != DONE) alu_z_next = (result_next == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      acc_reg    <= '0;
      func_reg   <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      alu_z_reg  <= 1'b0;
      div0_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      acc_reg    <= acc_next;
      func_reg   <= func_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      alu_z_reg  <= alu_z_next;
      div0_reg   <= div0_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign alu_z     = alu_z_reg;
  assign div0      = div0_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table, random ops against a behavioural
// model, and hand-written reset/backpressure sequences, with a result scoreboard.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  func;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        alu_z;
  logic        div0;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .alu_z     (alu_z),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic [31:0] r;
    logic        z;
    logic        d;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        d;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vf,
                              input logic [31:0] vr, input logic vz, input logic vd,
                              input int vlat, input int vhold);
    vec_t v;
    v.a = va; v.b = vb; v.f = vf; v.r = vr; v.z = vz; v.d = vd; v.lat = vlat; v.hold = vhold;
    return v;
  endfunction

  function automatic vec_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mf);
    logic [31:0] r;
    logic        d;
    int          lat;
    d   = 1'b0;
    lat = 1;
    case (mf)
      4'd1:  r = ma - mb;
      4'd3:  begin r = ma * mb; lat = 33; end
      4'd4:  if (mb == 0) begin r = 32'hFFFF_FFFF; d = 1'b1; end else begin r = ma / mb; lat = 33; end
      4'd5:  if (mb == 0) begin r = ma; d = 1'b1; end else begin r = ma % mb; lat = 33; end
      4'd6:  r = ma << mb[4:0];
      4'd7:  r = ma >> mb[4:0];
      4'd8:  r = ma & mb;
      4'd9:  r = ma | mb;
      4'd10: r = ma ^ mb;
      4'd13: r = {31'b0, ma == mb};
      4'd14: r = {31'b0, ma != mb};
      default: r = ma + mb;
    endcase
    return mk(ma, mb, mf, r, r == 0, d, lat, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   n;
    int   lat;
    logic busy_bad;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = v.a; b = v.b; func = v.f; in_valid = 1'b1; out_ready = (v.hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; func = 4'($urandom_range(0, 15));
    e.r = v.r; e.z = v.z; e.d = v.d;
    sb.push_back(e);
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_bad = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    if (v.lat > 1) chk("busy_in_ready", 32'(busy_bad), 32'd0);
    for (int i = 0; i < v.hold; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", result, v.r);
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("result", result, e.r);
      chk("alu_z", 32'(alu_z), 32'(e.z));
      chk("div0", 32'(div0), 32'(e.d));
    end
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
    $display("op func=%0d a=%h b=%h -> result=%h z=%0b div0=%0b latency=%0d",
             v.f, v.a, v.b, result, alu_z, div0, lat);
    @(posedge clk); #1;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; func = '0;

    vt.push_back(mk(32'd5,          32'd7,          4'd0,  32'd12,         1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'hFFFF_FFFF,  32'd2,          4'd3,  32'hFFFF_FFFE,  1'b0, 1'b0, 33, 0));
    vt.push_back(mk(32'd100,        32'd7,          4'd4,  32'd14,         1'b0, 1'b0, 33, 0));
    vt.push_back(mk(32'd100,        32'd7,          4'd5,  32'd2,          1'b0, 1'b0, 33, 0));
    vt.push_back(mk(32'd9,          32'd0,          4'd4,  32'hFFFF_FFFF,  1'b0, 1'b1,  1, 0));
    vt.push_back(mk(32'd9,          32'd0,          4'd5,  32'd9,          1'b0, 1'b1,  1, 0));
    vt.push_back(mk(32'd0,          32'd0,          4'd5,  32'd0,          1'b1, 1'b1,  1, 0));
    vt.push_back(mk(32'd5,          32'd5,          4'd1,  32'd0,          1'b1, 1'b0,  1, 0));
    vt.push_back(mk(32'd1,          32'h23,         4'd6,  32'd8,          1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'h8000_0000,  32'h3F,         4'd7,  32'd1,          1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'hF0F0,       32'hFF00,       4'd8,  32'hF000,       1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'hF0F0,       32'hFF00,       4'd9,  32'hFFF0,       1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'hF0F0,       32'hFF00,       4'd10, 32'h0FF0,       1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'd3,          32'd3,          4'd13, 32'd1,          1'b0, 1'b0,  1, 5));
    vt.push_back(mk(32'd3,          32'd3,          4'd14, 32'd0,          1'b1, 1'b0,  1, 0));
    vt.push_back(mk(32'hFFFF_FFFF,  32'd1,          4'd2,  32'd0,          1'b1, 1'b0,  1, 0));
    vt.push_back(mk(32'd10,         32'd20,         4'd11, 32'd30,         1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'd11,         32'd22,         4'd12, 32'd33,         1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'd1,          32'd2,          4'd15, 32'd3,          1'b0, 1'b0,  1, 0));
    vt.push_back(mk(32'h0001_0000,  32'h0001_0000,  4'd3,  32'd0,          1'b1, 1'b0, 33, 0));
    vt.push_back(mk(32'hFFFF_FFFF,  32'd1,          4'd4,  32'hFFFF_FFFF,  1'b0, 1'b0, 33, 0));
    vt.push_back(mk(32'd7,          32'd100,        4'd5,  32'd7,          1'b0, 1'b0, 33, 2));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_z", 32'(alu_z), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    foreach (vt[i]) run_op(vt[i]);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [3:0]  rf;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rf = (i < 4) ? 4'(3 + i % 3) : 4'($urandom_range(0, 15));
      run_op(model(ra, rb, rf));
    end

    // Reset in the middle of a divide, while a nonzero earlier result is still held.
    run_op(mk(32'd40, 32'd2, 4'd0, 32'd42, 1'b0, 1'b0, 1, 0));
    a = 32'd100; b = 32'd7; func = 4'd4; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("div_busy", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_no_valid", 32'(out_valid), 32'd0);
    run_op(mk(32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b0, 1, 0));

    // Reset while a result is waiting in DONE.
    a = 32'd1; b = 32'd2; func = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("donerst_out_valid", 32'(out_valid), 32'd0);
    chk("donerst_result", result, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op(mk(32'd6, 32'd6, 4'd13, 32'd1, 1'b0, 1'b0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
